// File: rtl/uidbufr_interconnect_pkg.sv
`default_nettype none
// ============================================================================
// Package : uidbufr_interconnect_pkg
// Shared FDMA interconnect constants and FSM encodings (read and write side).
// Revision: 1.0
// ============================================================================
package uidbufr_interconnect_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_IDX_W = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } rd_state_t;

  localparam int WR_NUM_CH   = 4;
  localparam int WR_CH_IDX_W = 2;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_BUSY = 2'd2,
    W_DONE = 2'd3
  } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/uidbuf_rr_arb4.sv
`default_nettype none
// ============================================================================
// Module  : uidbuf_rr_arb4
// Four-way round-robin arbiter; search starts at the channel after 'last'.
// Revision: 1.0
// ============================================================================
module uidbuf_rr_arb4
  import uidbufr_interconnect_pkg::*;
(
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_IDX_W-1:0] last,
  output logic [CH_IDX_W-1:0] gnt_idx,
  output logic                gnt_valid
);

  logic [CH_IDX_W-1:0] idx;

  // Scan farthest-first so the nearest requester after 'last' wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = last + CH_IDX_W'(k);
      if (req[idx]) begin
        gnt_idx   = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uidbufr_interconnect.sv
`default_nettype none
// ============================================================================
// Module  : uidbufr_interconnect
// Arbitrates four FDMA read requesters onto one FDMA read port, one burst at a time.
// Revision: 1.0
// ============================================================================
module uidbufr_interconnect
  import uidbufr_interconnect_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 23
)(
  input  logic                      ui_clk,
  input  logic                      ui_rst,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_1,
  input  logic                      fdma_rareq_1,
  input  logic [15:0]               fdma_rsize_1,
  output logic                      fdma_rbusy_1,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_1,
  output logic                      fdma_rvalid_1,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_2,
  input  logic                      fdma_rareq_2,
  input  logic [15:0]               fdma_rsize_2,
  output logic                      fdma_rbusy_2,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_2,
  output logic                      fdma_rvalid_2,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_3,
  input  logic                      fdma_rareq_3,
  input  logic [15:0]               fdma_rsize_3,
  output logic                      fdma_rbusy_3,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_3,
  output logic                      fdma_rvalid_3,

  input  logic [AXI_ADDR_WIDTH-1:0] fdma_raddr_4,
  input  logic                      fdma_rareq_4,
  input  logic [15:0]               fdma_rsize_4,
  output logic                      fdma_rbusy_4,
  output logic [AXI_DATA_WIDTH-1:0] fdma_rdata_4,
  output logic                      fdma_rvalid_4,

  output logic [AXI_ADDR_WIDTH-1:0] fdma_raddr,
  output logic                      fdma_rareq,
  output logic [15:0]               fdma_rsize,
  input  logic                      fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0] fdma_rdata,
  input  logic                      fdma_rvalid
);

  rd_state_t                 state, state_nxt;
  logic [CH_IDX_W-1:0]       rr_ptr, gnt_idx, arb_idx;
  logic                      arb_valid, grant, in_burst;
  logic [AXI_ADDR_WIDTH-1:0] raddr_ch [NUM_CH];
  logic [15:0]               rsize_ch [NUM_CH];
  logic [NUM_CH-1:0]         rareq_ch, rbusy_ch, rvalid_ch;
  logic [AXI_ADDR_WIDTH-1:0] raddr_q;
  logic [15:0]               rsize_q;
  logic                      rareq_q;

  assign raddr_ch[0] = fdma_raddr_1;
  assign raddr_ch[1] = fdma_raddr_2;
  assign raddr_ch[2] = fdma_raddr_3;
  assign raddr_ch[3] = fdma_raddr_4;
  assign rsize_ch[0] = fdma_rsize_1;
  assign rsize_ch[1] = fdma_rsize_2;
  assign rsize_ch[2] = fdma_rsize_3;
  assign rsize_ch[3] = fdma_rsize_4;
  assign rareq_ch    = {fdma_rareq_4, fdma_rareq_3, fdma_rareq_2, fdma_rareq_1};

  uidbuf_rr_arb4 u_arb (
    .req       (rareq_ch),
    .last      (rr_ptr),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // The controller must be idle too, so a burst abandoned by reset drains first.
  assign grant = (state == S_IDLE) && !fdma_rbusy && arb_valid;

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (grant)       state_nxt = S_REQ;
      S_REQ:  if (fdma_rbusy)  state_nxt = S_BUSY;
      S_BUSY: if (!fdma_rbusy) state_nxt = S_DONE;
      S_DONE:                  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      rr_ptr  <= CH_IDX_W'(NUM_CH - 1);
      gnt_idx <= '0;
      raddr_q <= '0;
      rsize_q <= '0;
      rareq_q <= 1'b0;
    end else begin
      if (grant) begin
        gnt_idx <= arb_idx;
        raddr_q <= raddr_ch[arb_idx];
        rsize_q <= rsize_ch[arb_idx];
        rareq_q <= 1'b1;
      end else if ((state == S_REQ) && fdma_rbusy) begin
        rareq_q <= 1'b0;
      end
      if (state == S_DONE) rr_ptr <= gnt_idx;
    end
  end

  assign in_burst = (state == S_REQ) || (state == S_BUSY);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign rbusy_ch[g]  = in_burst && (gnt_idx == CH_IDX_W'(g));
    assign rvalid_ch[g] = (state == S_BUSY) && fdma_rvalid && (gnt_idx == CH_IDX_W'(g));
  end

  assign fdma_raddr    = raddr_q;
  assign fdma_rsize    = rsize_q;
  assign fdma_rareq    = rareq_q;

  assign fdma_rbusy_1  = rbusy_ch[0];
  assign fdma_rbusy_2  = rbusy_ch[1];
  assign fdma_rbusy_3  = rbusy_ch[2];
  assign fdma_rbusy_4  = rbusy_ch[3];
  assign fdma_rvalid_1 = rvalid_ch[0];
  assign fdma_rvalid_2 = rvalid_ch[1];
  assign fdma_rvalid_3 = rvalid_ch[2];
  assign fdma_rvalid_4 = rvalid_ch[3];
  assign fdma_rdata_1  = fdma_rdata;
  assign fdma_rdata_2  = fdma_rdata;
  assign fdma_rdata_3  = fdma_rdata;
  assign fdma_rdata_4  = fdma_rdata;

endmodule
`default_nettype wire
